zbt_sram_arbiter: RTL and testbench

Single-port arbiter that shares one ZBT SRAM chip between a read requester (display scan-out) and a write requester (pixel/sample writer). It accepts at most one access per cycle, drives the RAM address, write-enable and bidirectional data bus with correct ZBT pipeline alignment, and returns read data with a fixed latency. It runs on the deskewed `fpga_clock` domain and stays idle until the RAM clock DCMs report lock.

---
 rtl/zbt_sram_arbiter.sv | 123 ++++++++++++
 tb/tb_zbt_sram_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zbt_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : zbt_sram_arbiter
// Brief    : Shares one ZBT SRAM between a read and a write requester, one
//            access per cycle, with ZBT-aligned late write and fixed-latency
//            read return. Define ZBT_ARB_RR_EN for round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module zbt_sram_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 36,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              locked,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we_b,
    output logic [DATA_W-1:0] ram_data_out,
    output logic              ram_data_oe,
    input  logic [DATA_W-1:0] ram_data_in
);

    localparam int c_TAG_W = RD_LATENCY + 1;

    logic              w_arb_en;
    logic              w_rd_grant;
    logic              w_wr_grant;
    logic [DATA_W-1:0] r_wr_data_s1;
    logic [DATA_W-1:0] r_wr_data_s2;
    logic              r_wr_vld_s1;
    logic              r_wr_vld_s2;
    logic [c_TAG_W-1:0] r_rd_tag;

    assign w_arb_en = locked & ~reset;

`ifdef ZBT_ARB_RR_EN
    // 1 = most recent grant went to the reader; resets to "write" so the
    // first contended cycle favours the reader.
    logic r_last_rd;

    always_comb begin
        w_rd_grant = 1'b0;
        w_wr_grant = 1'b0;
        if (w_arb_en) begin
            if (rd_req && wr_req) begin
                w_rd_grant = ~r_last_rd;
                w_wr_grant = r_last_rd;
            end else begin
                w_rd_grant = rd_req;
                w_wr_grant = wr_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_rd <= 1'b0;
        end else if (w_rd_grant || w_wr_grant) begin
            r_last_rd <= w_rd_grant;
        end
    end
`else
    assign w_rd_grant = w_arb_en & rd_req;
    assign w_wr_grant = w_arb_en & wr_req & ~rd_req;
`endif

    assign rd_ack = w_rd_grant;
    assign wr_ack = w_wr_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr     <= '0;
            ram_we_b     <= 1'b1;
            ram_data_out <= '0;
            ram_data_oe  <= 1'b0;
            r_wr_data_s1 <= '0;
            r_wr_data_s2 <= '0;
            r_wr_vld_s1  <= 1'b0;
            r_wr_vld_s2  <= 1'b0;
            r_rd_tag     <= '0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
        end else begin
            // Idle cycles issue a harmless read at the held address.
            ram_we_b <= ~w_wr_grant;
            if (w_wr_grant) begin
                ram_addr <= wr_addr;
            end else if (w_rd_grant) begin
                ram_addr <= rd_addr;
            end

            // Late write: data lands on the bus two cycles after its address.
            r_wr_vld_s1 <= w_wr_grant;
            r_wr_vld_s2 <= r_wr_vld_s1;
            ram_data_oe <= r_wr_vld_s2;
            if (w_wr_grant) begin
                r_wr_data_s1 <= wr_data;
            end
            r_wr_data_s2 <= r_wr_data_s1;
            if (r_wr_vld_s2) begin
                ram_data_out <= r_wr_data_s2;
            end

            r_rd_tag <= {r_rd_tag[RD_LATENCY-1:0], w_rd_grant};
            rd_valid <= r_rd_tag[RD_LATENCY];
            if (r_rd_tag[RD_LATENCY]) begin
                rd_data <= ram_data_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zbt_sram_arbiter.sv
`default_nettype none
// Bench for zbt_sram_arbiter: ZBT RAM model, transaction-level reference model
// with a per-cycle compare process, directed scenarios and random traffic.
module tb_zbt_sram_arbiter;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 36;
  localparam int RD_LATENCY = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic locked = 1'b0;
  logic rd_req = 1'b0;
  logic wr_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] rd_data, ram_data_out;
  logic [DATA_W-1:0] ram_data_in = '0;
  logic rd_ack, wr_ack, rd_valid, ram_we_b, ram_data_oe;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  zbt_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY)) dut (
    .clk(clk), .reset(reset), .locked(locked),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ram_addr(ram_addr), .ram_we_b(ram_we_b), .ram_data_out(ram_data_out),
    .ram_data_oe(ram_data_oe), .ram_data_in(ram_data_in)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[DATA_W-1:0];
  endfunction

  // ZBT RAM: op issued in address cycle A uses the data bus in cycle A+2.
  logic [DATA_W-1:0] ram_mem [1024];
  bit   p_we_b [3] = '{1'b1, 1'b1, 1'b1};
  logic [9:0] p_addr [3] = '{10'd0, 10'd0, 10'd0};

  always @(negedge clk) begin
    p_we_b[2] = p_we_b[1]; p_addr[2] = p_addr[1];
    p_we_b[1] = p_we_b[0]; p_addr[1] = p_addr[0];
    p_we_b[0] = ram_we_b;  p_addr[0] = ram_addr[9:0];
    if (p_we_b[2]) begin
      if (chk_en) chk("bus_contention_oe", 64'(ram_data_oe), 64'd0);
      ram_data_in = ram_mem[p_addr[2]];
    end else begin
      if (chk_en) chk("late_write_oe", 64'(ram_data_oe), 64'd1);
      if (ram_data_oe) ram_mem[p_addr[2]] = ram_data_out;
      ram_data_in = rand_data();
    end
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        p_we_b[i] = 1'b1;
        p_addr[i] = '0;
      end
    end
  end

  // Reference model: grants decided from the arbitration rules, results
  // scheduled at fixed offsets from the grant cycle.
  logic [DATA_W-1:0] ref_mem [1024];
  bit   ref_known [1024];
  bit   rd_due [8];
  bit   rd_due_known [8];
  logic [DATA_W-1:0] rd_due_data [8];
  bit   wr_due [8];
  logic [9:0] wr_due_addr [8];
  logic [DATA_W-1:0] wr_due_data [8];
  bit   exp_we_b = 1'b1;
  logic [ADDR_W-1:0] exp_addr = '0;
  bit   last_rd = 1'b0;
  int   cyc = 0;
  bit   obs_rd_ack = 1'b0;
  bit   obs_wr_ack = 1'b0;

  always @(negedge clk) begin
    bit e_rd, e_wr;
    int s, sr, sw;
    e_rd = 1'b0;
    e_wr = 1'b0;
    if (locked && !reset) begin
`ifdef ZBT_ARB_RR_EN
      if (rd_req && wr_req) begin
        e_rd = !last_rd;
        e_wr = last_rd;
      end else begin
        e_rd = rd_req;
        e_wr = wr_req;
      end
`else
      e_rd = rd_req;
      e_wr = wr_req && !rd_req;
`endif
    end
    obs_rd_ack = rd_ack;
    obs_wr_ack = wr_ack;
    if (chk_en) begin
      s  = cyc % 8;
      sr = (cyc + RD_LATENCY + 2) % 8;
      sw = (cyc + 3) % 8;
      chk("rd_ack", 64'(rd_ack), 64'(e_rd));
      chk("wr_ack", 64'(wr_ack), 64'(e_wr));
      chk("ram_we_b", 64'(ram_we_b), 64'(exp_we_b));
      chk("ram_addr", 64'(ram_addr), 64'(exp_addr));
      chk("rd_valid", 64'(rd_valid), 64'(rd_due[s]));
      if (rd_due[s] && rd_due_known[s]) chk("rd_data", 64'(rd_data), 64'(rd_due_data[s]));
      chk("ram_data_oe", 64'(ram_data_oe), 64'(wr_due[s]));
      if (wr_due[s]) chk("ram_data_out", 64'(ram_data_out), 64'(wr_due_data[s]));
      rd_due[s] = 1'b0;
      wr_due[s] = 1'b0;
      exp_we_b = 1'b1;
      if (e_rd) begin
        rd_due[sr] = 1'b1;
        rd_due_known[sr] = ref_known[rd_addr[9:0]];
        rd_due_data[sr] = ref_mem[rd_addr[9:0]];
        exp_addr = rd_addr;
        last_rd = 1'b1;
      end else if (e_wr) begin
        ref_mem[wr_addr[9:0]] = wr_data;
        ref_known[wr_addr[9:0]] = 1'b1;
        wr_due[sw] = 1'b1;
        wr_due_addr[sw] = wr_addr[9:0];
        wr_due_data[sw] = wr_data;
        exp_we_b = 1'b0;
        exp_addr = wr_addr;
        last_rd = 1'b0;
      end
      if (reset) begin
        // Writes dropped by reset leave their RAM word undefined.
        for (int i = 0; i < 8; i++) begin
          if (wr_due[i]) ref_known[wr_due_addr[i]] = 1'b0;
          wr_due[i] = 1'b0;
          rd_due[i] = 1'b0;
        end
        exp_we_b = 1'b1;
        exp_addr = '0;
        last_rd = 1'b0;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic chk_reset_values();
    chk("rst_rd_ack", 64'(rd_ack), 64'd0);
    chk("rst_wr_ack", 64'(wr_ack), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_we_b", 64'(ram_we_b), 64'd1);
    chk("rst_ram_data_out", 64'(ram_data_out), 64'd0);
    chk("rst_ram_data_oe", 64'(ram_data_oe), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rn, wn;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
      ref_known[i] = 1'b1;
    end
    step();
    chk_en = 1'b1;
    #1 chk_reset_values();
    step();
    reset = 1'b0;
    locked = 1'b1;

    // Write then read back the same word.
    step();
    wr_req = 1'b1; wr_addr = 19'h00010; wr_data = 36'h123456789;
    #1 chk("t1_wr_ack", 64'(wr_ack), 64'd1);
    step(); wr_req = 1'b0;
    #1 chk("t1_we_b_g1", 64'(ram_we_b), 64'd0);
    chk("t1_addr_g1", 64'(ram_addr), 64'h10);
    step(); #1 chk("t1_oe_g2", 64'(ram_data_oe), 64'd0);
    step(); #1 chk("t1_oe_g3", 64'(ram_data_oe), 64'd1);
    chk("t1_data_g3", 64'(ram_data_out), 64'h123456789);
    step();
    rd_req = 1'b1; rd_addr = 19'h00010;
    #1 chk("t1_rd_ack", 64'(rd_ack), 64'd1);
    step(); rd_req = 1'b0;
    step();
    step(); #1 chk("t1_rd_valid_r3", 64'(rd_valid), 64'd0);
    step(); #1 chk("t1_rd_valid_r4", 64'(rd_valid), 64'd1);
    chk("t1_rd_data", 64'(rd_data), 64'h123456789);

    // No grants while unlocked.
    do_reset();
    locked = 1'b0; rd_req = 1'b1; wr_req = 1'b1; rd_addr = 19'h30; wr_addr = 19'h31;
    for (int k = 0; k < 10; k++) begin
      #1 chk("t2_no_rd_ack", 64'(rd_ack), 64'd0);
      chk("t2_no_wr_ack", 64'(wr_ack), 64'd0);
      chk("t2_we_b", 64'(ram_we_b), 64'd1);
      step();
    end
    locked = 1'b1;
    #1 chk("t2_rd_ack_on_lock", 64'(rd_ack), 64'd1);
    chk("t2_wr_ack_on_lock", 64'(wr_ack), 64'd0);
    step(); rd_req = 1'b0; wr_req = 1'b0;

    // Contention for 8 cycles.
    do_reset();
    rn = 0; wn = 0;
    for (int k = 0; k < 8; k++) begin
      rd_req = 1'b1; wr_req = 1'b1;
      rd_addr = ADDR_W'(32'h200 + rn); wr_addr = ADDR_W'(32'h100 + wn); wr_data = rand_data();
      #1;
`ifdef ZBT_ARB_RR_EN
      chk("t3_rr_order", 64'(rd_ack), 64'(k % 2 == 0));
`endif
      if (rd_ack) rn++;
      if (wr_ack) wn++;
      step();
    end
    rd_req = 1'b0; wr_req = 1'b0;
`ifdef ZBT_ARB_RR_EN
    chk("t3_rd_count", 64'(rn), 64'd4);
    chk("t3_wr_count", 64'(wn), 64'd4);
`else
    chk("t3_rd_count", 64'(rn), 64'd8);
    chk("t3_wr_count", 64'(wn), 64'd0);
`endif

    // Alternating write/read to one address.
    for (int k = 0; k < 20; k++) begin
      step();
      wr_req = (k % 2 == 0); rd_req = (k % 2 == 1);
      wr_addr = 19'h40; rd_addr = 19'h40; wr_data = rand_data();
    end
    step(); rd_req = 1'b0; wr_req = 1'b0;
    repeat (6) step();

    // Reset one cycle after a read ack, then one cycle after a write ack.
    for (int t = 0; t < 2; t++) begin
      step();
      if (t == 0) begin rd_req = 1'b1; rd_addr = 19'h3FE; end
      else begin wr_req = 1'b1; wr_addr = 19'h3FF; wr_data = 36'hFEDCBA987; end
      #1 chk("t5_ack", 64'(rd_ack | wr_ack), 64'd1);
      step(); rd_req = 1'b0; wr_req = 1'b0; reset = 1'b1;
      step(); reset = 1'b0;
      #1 chk_reset_values();
      for (int k = 0; k < 5; k++) begin
        step();
        #1 chk("t5_no_rd_valid", 64'(rd_valid), 64'd0);
        chk("t5_no_oe", 64'(ram_data_oe), 64'd0);
      end
    end

    // Lock lost the cycle after a write ack.
    step();
    wr_req = 1'b1; wr_addr = 19'h20; d = rand_data(); wr_data = d;
    #1 chk("t6_wr_ack", 64'(wr_ack), 64'd1);
    step(); locked = 1'b0; rd_req = 1'b1; wr_req = 1'b1; wr_data = rand_data();
    #1 chk("t6_no_ack_g1", 64'(rd_ack | wr_ack), 64'd0);
    step(); #1 chk("t6_oe_g2", 64'(ram_data_oe), 64'd0);
    step(); #1 chk("t6_oe_g3", 64'(ram_data_oe), 64'd1);
    chk("t6_data_g3", 64'(ram_data_out), 64'(d));
    step(); #1 chk("t6_oe_g4", 64'(ram_data_oe), 64'd0);
    chk("t6_no_ack_g4", 64'(rd_ack | wr_ack), 64'd0);
    rd_req = 1'b0; wr_req = 1'b0; locked = 1'b1;

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      step();
      reset = ($urandom_range(0, 299) == 0);
      locked = ($urandom_range(0, 15) != 0);
      if (!rd_req || obs_rd_ack) begin
        rd_req = 1'($urandom_range(0, 1));
        rd_addr = ADDR_W'($urandom_range(0, 63));
      end
      if (!wr_req || obs_wr_ack) begin
        wr_req = 1'($urandom_range(0, 1));
        wr_addr = ADDR_W'($urandom_range(0, 63));
        wr_data = rand_data();
      end
    end
    step(); reset = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
